// File: rtl/multicycle_ws_controller_pkg.sv
// Shared encodings for the multicycle processor: controller state,
// opcodes, datapath select values and the control-word layout.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
        I_EX, I_WB, BRANCH, JUMP, JAL, FAULT
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] AOP_ADD  = 2'b00;
    localparam logic [1:0] AOP_SUB  = 2'b01;
    localparam logic [1:0] AOP_FUNC = 2'b10;
    localparam logic [1:0] AOP_SLT  = 2'b11;

    // Every datapath control the FSM drives, zeroed as one word.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       reg_write;
        logic       alu_src_a;
        logic       instr_done;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ws_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller side.
interface multicycle_ws_controller_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_read, mem_write;
    logic       IorD, IR_write, pc_write, pc_write_cond, pc_write_cond_ne;
    logic       reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src, alu_op;
    logic       instr_done, illegal_op, bus_error;

    modport master (
        input  opcode, mem_ready,
        output mem_read, mem_write, IorD, IR_write, pc_write, pc_write_cond,
               pc_write_cond_ne, reg_write, alu_src_a, reg_dst, mem_to_reg,
               alu_src_b, pc_src, alu_op, instr_done, illegal_op, bus_error
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_read, mem_write, IorD, IR_write, pc_write, pc_write_cond,
               pc_write_cond_ne, reg_write, alu_src_a, reg_dst, mem_to_reg,
               alu_src_b, pc_src, alu_op, instr_done, illegal_op, bus_error
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts wait cycles of one memory access and flags the last permitted
// wait cycle. MEM_TIMEOUT = 0 never flags.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic limit_hit
);
    localparam int unsigned CW_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: restart on access entry, otherwise step per wait cycle.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; the
        // default-first assignment is what keeps a latch from being inferred.
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + CW'(1);
    end

    // Wait-count register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so all flops sample the same
        // pre-edge values regardless of block ordering.
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    // The current wait cycle is the last one allowed; a miss here times out.
    assign limit_hit = (MEM_TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ws_controller.sv
// Multicycle control FSM with wait-state memory handshake, access timeout
// and sticky fault flags.
module multicycle_ws_controller
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          SUPPORT_JAL = 1'b1
) (
    input logic                         clk,
    input logic                         rst,
    multicycle_ws_controller_if.master  bus
);
    state_e state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   bus_error_q, bus_error_d;
    logic   in_access, limit_hit;
    ctrl_t  ctl;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_d != state_q),
        .inc       (in_access && !bus.mem_ready),
        .limit_hit (limit_hit)
    );

    // Next state, fault flags and control word for the current state.
    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        bus_error_d  = bus_error_q;
        in_access    = 1'b0;
        ctl          = '0;
        unique case (state_q)
            FETCH: begin
                in_access     = 1'b1;
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = ASB_FOUR;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = DECODE;
                end else if (limit_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end
            end
            DECODE: begin
                ctl.alu_src_b = ASB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = MEM_ADDR;
                    OP_RTYPE:         state_d = R_EX;
                    OP_ADDI, OP_SLTI: state_d = I_EX;
                    OP_BEQ, OP_BNE:   state_d = BRANCH;
                    OP_J:             state_d = JUMP;
                    OP_JAL: begin
                        state_d      = SUPPORT_JAL ? JAL : FAULT;
                        illegal_op_d = illegal_op_q | !SUPPORT_JAL;
                    end
                    default: begin
                        state_d      = FAULT;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_IMM;
                state_d       = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                in_access    = 1'b1;
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEM_WB;
                end else if (limit_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end
            end
            MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RT;
                ctl.mem_to_reg = MTR_MDR;
                ctl.instr_done = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                in_access     = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctl.instr_done = 1'b1;
                    state_d        = FETCH;
                end else if (limit_hit) begin
                    bus_error_d = 1'b1;
                    state_d     = FAULT;
                end
            end
            R_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_B;
                ctl.alu_op    = AOP_FUNC;
                state_d       = R_WB;
            end
            R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = RD_RD;
                ctl.mem_to_reg = MTR_ALUOUT;
                ctl.instr_done = 1'b1;
                state_d        = FETCH;
            end
            I_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_IMM;
                ctl.alu_op    = (bus.opcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
                state_d       = I_WB;
            end
            I_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_d        = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a        = 1'b1;
                ctl.alu_src_b        = ASB_B;
                ctl.alu_op           = AOP_SUB;
                ctl.pc_src           = PCS_ALUOUT;
                ctl.pc_write_cond    = (bus.opcode == OP_BEQ);
                ctl.pc_write_cond_ne = (bus.opcode == OP_BNE);
                ctl.instr_done       = 1'b1;
                state_d              = FETCH;
            end
            JUMP, JAL: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_src     = PCS_JUMP;
                ctl.instr_done = 1'b1;
                if (state_q == JAL) begin
                    ctl.reg_write  = 1'b1;
                    ctl.reg_dst    = RD_RA;
                    ctl.mem_to_reg = MTR_PC;
                end
                state_d = FETCH;
            end
            FAULT:   state_d = FAULT;
            default: state_d = FETCH;
        endcase
        // Reset holds every control quiet even though state already reads FETCH.
        if (!rst) ctl = '0;
    end

    // State and sticky fault flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            illegal_op_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign bus.mem_read         = ctl.mem_read;
    assign bus.mem_write        = ctl.mem_write;
    assign bus.IorD             = ctl.iord;
    assign bus.IR_write         = ctl.ir_write;
    assign bus.pc_write         = ctl.pc_write;
    assign bus.pc_write_cond    = ctl.pc_write_cond;
    assign bus.pc_write_cond_ne = ctl.pc_write_cond_ne;
    assign bus.reg_write        = ctl.reg_write;
    assign bus.alu_src_a        = ctl.alu_src_a;
    assign bus.reg_dst          = ctl.reg_dst;
    assign bus.mem_to_reg       = ctl.mem_to_reg;
    assign bus.alu_src_b        = ctl.alu_src_b;
    assign bus.pc_src           = ctl.pc_src;
    assign bus.alu_op           = ctl.alu_op;
    assign bus.instr_done       = ctl.instr_done;
    assign bus.illegal_op       = illegal_op_q;
    assign bus.bus_error        = bus_error_q;

endmodule
